// File: rtl/fetch_decode_unit_pkg.sv
// Shared definitions for the fetch/decode unit, program ROM and execute stage:
// opcodes, register names, instruction field positions and fetch states.
package fetch_decode_unit_pkg;

  localparam int OPC_HI   = 27;
  localparam int OPC_LO   = 24;
  localparam int DEST_HI  = 23;
  localparam int DEST_LO  = 16;
  localparam int SRC1_HI  = 15;
  localparam int SRC1_LO  = 8;
  localparam int SRC0_HI  = 7;
  localparam int SRC0_LO  = 0;
  localparam int IMM16_HI = 15;
  localparam int IMM24_HI = 23;
  localparam int DELAY_W  = 24;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_STO = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_JMP = 4'd4,
    OP_LED = 4'd5
  } opcode_e;

  localparam logic [7:0] R0 = 8'd0;
  localparam logic [7:0] R1 = 8'd1;
  localparam logic [7:0] R2 = 8'd2;
  localparam logic [7:0] R3 = 8'd3;
  localparam logic [7:0] R4 = 8'd4;
  localparam logic [7:0] R5 = 8'd5;
  localparam logic [7:0] R6 = 8'd6;
  localparam logic [7:0] R7 = 8'd7;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DELAY = 1'b1
  } state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_decode_unit_delay_counter.sv
// Loadable down-counter timing NOP delays; clear beats load, load beats decrement.
module delay_counter
  import fetch_decode_unit_pkg::*;
#(
  parameter int W = DELAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Countdown register; never decrements below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/fetch_decode_unit.sv
// Program counter, ROM fetch and field decode with local NOP delay and JMP handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic               oValid,
  output logic [3:0]         oOpcode,
  output logic [7:0]         oDest,
  output logic [7:0]         oSrc1,
  output logic [7:0]         oSrc0,
  output logic [15:0]        oImm16,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oDelayBusy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        oIssueCount,
  output logic [31:0]        oBubbleCount
`endif
);

  state_e               state_r;
  logic [ADDR_W-1:0]    pc_r;
  logic [ADDR_W-1:0]    dpc_r;
  logic [INSTR_W-1:0]   instr_r;
  logic                 valid_r;
  logic                 busy_r;

  logic [3:0]           opcode_s;
  logic [DELAY_W-1:0]   imm24_s;
  logic [15:0]          imm16_s;
  logic [ADDR_W-1:0]    pc_inc_s;
  logic                 last_s;
  logic                 cnt_load_s;
  logic                 cnt_en_s;
  logic [DELAY_W-1:0]   cnt_s;
  logic                 cnt_zero_s;

  // Field extraction of the word at PC and counter control for this cycle.
  always_comb begin
    opcode_s   = iInstruction[OPC_HI:OPC_LO];
    imm24_s    = iInstruction[IMM24_HI:0];
    imm16_s    = iInstruction[IMM16_HI:0];
    pc_inc_s   = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    last_s     = (cnt_s == 24'd1) || cnt_zero_s;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    if (iBranchTaken || iStall) begin
      cnt_load_s = 1'b0;
      cnt_en_s   = 1'b0;
    end else if (state_r == ST_RUN) begin
      cnt_load_s = (opcode_s == OP_NOP);
      cnt_en_s   = 1'b0;
    end else begin
      cnt_load_s = 1'b0;
      cnt_en_s   = 1'b1;
    end
  end

  delay_counter #(.W(DELAY_W)) u_delay (
    .clk        (Clock),
    .rst        (Reset),
    .clear      (iBranchTaken),
    .load       (cnt_load_s),
    .en         (cnt_en_s),
    .load_value (imm24_s),
    .count      (cnt_s),
    .zero       (cnt_zero_s)
  );

  // Fetch FSM: redirect beats stall, stall freezes everything, else run or count down.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_RUN;
      pc_r    <= RESET_PC;
      dpc_r   <= {ADDR_W{1'b0}};
      instr_r <= {INSTR_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (iBranchTaken) begin
      state_r <= ST_RUN;
      pc_r    <= iBranchTarget;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (iStall) begin
      state_r <= state_r;
      pc_r    <= pc_r;
      valid_r <= valid_r;
      busy_r  <= busy_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          instr_r <= iInstruction;
          dpc_r   <= pc_r;
          pc_r    <= pc_inc_s;
          case (opcode_s)
            OP_NOP: begin
              valid_r <= 1'b0;
              if (imm24_s != 24'd0) begin
                state_r <= ST_DELAY;
                busy_r  <= 1'b1;
              end else begin
                state_r <= ST_RUN;
                busy_r  <= 1'b0;
              end
            end
            OP_JMP: begin
              valid_r <= 1'b0;
              pc_r    <= ADDR_W'(imm16_s);
            end
            default: valid_r <= 1'b1;
          endcase
        end
        ST_DELAY: begin
          valid_r <= 1'b0;
          if (last_s) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_DELAY;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_RUN;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oAddress   = pc_r;
  assign oValid     = valid_r;
  assign oOpcode    = instr_r[OPC_HI:OPC_LO];
  assign oDest      = instr_r[DEST_HI:DEST_LO];
  assign oSrc1      = instr_r[SRC1_HI:SRC1_LO];
  assign oSrc0      = instr_r[SRC0_HI:SRC0_LO];
  assign oImm16     = instr_r[IMM16_HI:0];
  assign oPC        = dpc_r;
  assign oDelayBusy = busy_r;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] issue_cnt_r;
  logic [31:0] bubble_cnt_r;
  logic        bubble_s;

  // A bubble is any unstalled cycle that will not issue: flush, NOP, JMP or countdown.
  always_comb begin
    bubble_s = 1'b0;
    if (iBranchTaken) begin
      bubble_s = 1'b1;
    end else if (iStall) begin
      bubble_s = 1'b0;
    end else if (state_r == ST_DELAY) begin
      bubble_s = 1'b1;
    end else begin
      bubble_s = (opcode_s == OP_NOP) || (opcode_s == OP_JMP);
    end
  end

  // Saturating issue/bubble statistics.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      issue_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else begin
      issue_cnt_r  <= (valid_r && !iStall) ? sat_inc32(issue_cnt_r) : issue_cnt_r;
      bubble_cnt_r <= bubble_s ? sat_inc32(bubble_cnt_r) : bubble_cnt_r;
    end
  end

  assign oIssueCount  = issue_cnt_r;
  assign oBubbleCount = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench: directed scenarios plus random stall/redirect traffic
// against a cycle-level behavioural model of the fetch/decode rules.
module tb_fetch_decode_unit;
  import fetch_decode_unit_pkg::*;

  logic        Clock;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDest;
  logic [7:0]  oSrc1;
  logic [7:0]  oSrc0;
  logic [15:0] oImm16;
  logic [15:0] oPC;
  logic        oDelayBusy;

  logic [27:0] rom [0:65535];
  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_opc_pc;
  logic [27:0] m_instr;
  logic        m_valid;
  int          m_delay;

  fetch_decode_unit dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oValid(oValid), .oOpcode(oOpcode), .oDest(oDest), .oSrc1(oSrc1), .oSrc0(oSrc0),
    .oImm16(oImm16), .oPC(oPC), .oDelayBusy(oDelayBusy)
  );

  assign iInstruction = rom[oAddress];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [27:0] mk_imm(input logic [3:0] op, input logic [7:0] d, input logic [15:0] imm);
    return {op, d, imm};
  endfunction

  function automatic logic [27:0] mk24(input logic [3:0] op, input logic [23:0] imm);
    return {op, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'd0; m_opc_pc = 16'd0; m_instr = 28'd0; m_valid = 1'b0; m_delay = 0;
  endtask

  // one clock of architectural behaviour, using the inputs currently applied
  task automatic model_next();
    logic [27:0] w;
    w = rom[m_pc];
    if (iBranchTaken) begin
      m_pc = iBranchTarget; m_valid = 1'b0; m_delay = 0;
    end else if (iStall) begin
      m_pc = m_pc;
    end else if (m_delay > 0) begin
      m_delay = m_delay - 1; m_valid = 1'b0;
    end else begin
      m_instr = w; m_opc_pc = m_pc; m_pc = m_pc + 16'd1;
      if (w[27:24] == OP_NOP) begin
        m_valid = 1'b0; m_delay = int'(w[23:0]);
      end else if (w[27:24] == OP_JMP) begin
        m_valid = 1'b0; m_pc = w[15:0];
      end else begin
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".addr"},  64'(oAddress), 64'(m_pc));
    chk({tag, ".valid"}, 64'(oValid), 64'(m_valid));
    chk({tag, ".busy"},  64'(oDelayBusy), 64'(m_delay > 0));
    chk({tag, ".pc"},    64'(oPC), 64'(m_opc_pc));
    chk({tag, ".fields"}, 64'({oOpcode, oDest, oSrc1, oSrc0}), 64'(m_instr));
    chk({tag, ".imm16"}, 64'(oImm16), 64'(m_instr[15:0]));
  endtask

  task automatic step(input string tag);
    model_next();
    @(posedge Clock);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'd0;
    Reset = 1'b1;
    model_reset();
    @(posedge Clock);
    #1;
    compare_all(tag);
    Reset = 1'b0;
  endtask

  task automatic fill_add();
    for (int i = 0; i < 65536; i++) rom[i] = mk_imm(OP_ADD, R1, 16'h0203);
  endtask

  initial begin
    int nonissue;
    int busy;
    int r;
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'd0;

    // straight-line ADDs
    fill_add();
    do_reset("rst");
    chk("rst.addr0", 64'(oAddress), 64'd0);
    step("seq1");
    chk("seq1.pc0", 64'(oPC), 64'd0);
    chk("seq1.addr1", 64'(oAddress), 64'd1);
    step("seq2");
    step("seq3");
    chk("seq3.pc2", 64'(oPC), 64'd2);
    chk("seq3.addr3", 64'(oAddress), 64'd3);

    // NOP 4 then ADD
    rom[0] = mk24(OP_NOP, 24'd4);
    do_reset("nop.rst");
    nonissue = 0; busy = 0;
    for (int i = 0; i < 20 && oValid !== 1'b1; i++) begin
      step("nop4");
      if (oValid !== 1'b1) nonissue++;
      if (oDelayBusy === 1'b1) busy++;
    end
    chk("nop4.nonissue", 64'(nonissue), 64'd5);
    chk("nop4.busy", 64'(busy), 64'd4);
    chk("nop4.issue_pc", 64'(oPC), 64'd1);

    // JMP at address 2
    fill_add();
    rom[2] = mk_imm(OP_JMP, R0, 16'h0020);
    do_reset("jmp.rst");
    for (int i = 0; i < 3; i++) step("jmp");
    chk("jmp.addr", 64'(oAddress), 64'h20);
    chk("jmp.bubble", 64'(oValid), 64'd0);
    step("jmp.after");
    chk("jmp.issue_pc", 64'(oPC), 64'h20);
    chk("jmp.issue_valid", 64'(oValid), 64'd1);

    // stall with STO R3,#5 on the outputs
    rom[0] = mk_imm(OP_STO, R3, 16'd5);
    do_reset("stall.rst");
    step("sto");
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.dest", 64'(oDest), 64'd3);
      chk("stall.imm", 64'(oImm16), 64'd5);
      chk("stall.addr", 64'(oAddress), 64'd1);
    end
    iStall = 1'b0;
    step("unstall");
    chk("unstall.pc", 64'(oPC), 64'd1);
    chk("unstall.addr", 64'(oAddress), 64'd2);

    // redirect during a long countdown
    rom[0] = mk24(OP_NOP, 24'd4000);
    do_reset("abort.rst");
    for (int i = 0; i < 10; i++) step("cd");
    chk("cd.busy", 64'(oDelayBusy), 64'd1);
    iBranchTaken = 1'b1; iBranchTarget = 16'h0008;
    step("abort");
    iBranchTaken = 1'b0;
    chk("abort.busy", 64'(oDelayBusy), 64'd0);
    chk("abort.addr", 64'(oAddress), 64'd8);
    step("abort.next");
    chk("abort.issue_pc", 64'(oPC), 64'd8);

    // JMP fetched in the same cycle as a redirect
    rom[0] = mk_imm(OP_JMP, R0, 16'h0040);
    do_reset("jb.rst");
    iBranchTaken = 1'b1; iBranchTarget = 16'h0010;
    step("jb");
    iBranchTaken = 1'b0;
    chk("jb.addr", 64'(oAddress), 64'h10);

    // PC wrap and asynchronous reset
    fill_add();
    do_reset("wrap.rst");
    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    step("wrap.br");
    iBranchTaken = 1'b0;
    chk("wrap.ffff", 64'(oAddress), 64'hFFFF);
    step("wrap");
    chk("wrap.addr0", 64'(oAddress), 64'd0);
    chk("wrap.pc", 64'(oPC), 64'hFFFF);
    step("wrap.more");
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("async.addr", 64'(oAddress), 64'd0);
    chk("async.valid", 64'(oValid), 64'd0);
    Reset = 1'b0;

    // random program with random stalls, redirects and resets
    fill_add();
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)      rom[i] = mk24(OP_NOP, 24'($urandom_range(0, 6)));
      else if (r == 1) rom[i] = mk_imm(OP_JMP, 8'($urandom), 16'($urandom_range(0, 255)));
      else             rom[i] = 28'($urandom);
    end
    do_reset("rnd.rst");
    for (int i = 0; i < 600; i++) begin
      iStall        = ($urandom_range(0, 3) == 0);
      iBranchTaken  = ($urandom_range(0, 15) == 0);
      iBranchTarget = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) begin
        Reset = 1'b1;
        model_reset();
        #1;
        compare_all("rnd.async");
        Reset = 1'b0;
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
